dog_scan_ctrl: RTL and testbench
================================

// Module: dog_scan_ctrl
// PURPOSE
//  Frame sequencer for the 5x5 DoG filter unit. Drives its Xin/Yin/Directionin in a serpentine scan.
//  Issues the matching 5-pixel reads to the image line store: a column read per shift, a row read per turn.
//  Tags results: out_valid/out_last line up with the filter's registered DoG output.
//  Provides start/busy/done frame handshake and memory back-pressure.
// PARAMETERS
//  COLS      251  shifts per row; equals filter row-turn marker; image width = COLS+5
//  PIPE_LAT  5    cycles from dog_x issue to filter DoG output register
//  INIT_WAIT 3    cycles after reset release before start is accepted (filter warm-up)
// PORTS
//  clk        in   1  clock
//  rst        in   1  reset, asynchronous, active-high
//  start      in   1  frame start request, sampled in IDLE only
//  cfg_rows   in   8  output rows per frame, latched at start
//  mem_ready  in   1  line store can accept a read this cycle
//  ready      out  1  IDLE and INIT_WAIT elapsed
//  busy       out  1  frame in progress (PRIME..DRAIN)
//  done       out  1  one-cycle pulse at frame end
//  rd_en      out  1  read strobe; data due 1 cycle later on filter data1..5
//  rd_mode    out  1  0 = 5 vertical pixels (rows rd_row..+4, col rd_col); 1 = 5 horizontal (row rd_row, cols rd_col..+4)
//  rd_row     out  8  read row base
//  rd_col     out  8  read column (base)
//  dog_x      out  8  to filter Xin
//  dog_y      out  8  to filter Yin
//  dog_dir    out  1  to filter Directionin (0 = left-to-right)
//  out_valid  out  1  filter DoG output this cycle is a real result
//  out_last   out  1  final result of frame (qualifies out_valid)
// BEHAVIOUR
//  Reset: IDLE; ready/busy/done/rd_en/rd_mode/out_valid/out_last=0; dog_x=8'hFF; dog_y=0; dog_dir=0; rd_row=rd_col=0.
//  Reset: tag pipe and counters cleared; INIT_WAIT counter restarts.
//  No-op code: any cycle without rd_en drives dog_x=8'hFF (>COLS, so the filter holds its window).
//  IDLE:  ready=1 after INIT_WAIT.
//  IDLE:  start with cfg_rows=0 -> done pulse next cycle, no reads.
//  IDLE:  start with cfg_rows>0 -> PRIME, y=0, dir=0. start outside IDLE ignored.
//  PRIME: 5 issues, rd_mode=0, rd_row=0, rd_col=0..4, dog_x=0, dog_dir=0. Only the 5th is tagged valid.
//  SCAN:  x=0..COLS-1, dog_x=x, rd_mode=0, rd_row=y, all issues tagged valid.
//  SCAN:  rd_col = dir0: x+5; dir1: COLS-1-x.
//  SCAN:  after x=COLS-1 -> TURN if y<cfg_rows-1, else DRAIN.
//  TURN:  1 issue, dog_x=COLS, rd_mode=1, rd_row=y+5, tagged valid.
//  TURN:  rd_col = COLS if dir was 0, 0 if dir was 1.
//  TURN:  same cycle y<=y+1, dir<=~dir, x<=0 -> SCAN.
//  Issue: dog_y=y and dog_dir=dir (pre-update) on every issue.
//  Stall: mem_ready=0 in PRIME/SCAN/TURN -> no issue, rd_en=0, x/y/dir/state hold. Resume seamlessly.
//  Tag pipe: PIPE_LAT-deep shift register.
//  Tag pipe: out_valid = tag shifted in PIPE_LAT cycles earlier; out_last marks tag of the final SCAN issue.
//  DRAIN: wait until tag pipe empty; done pulses the cycle after out_last; -> IDLE.
//  Counts: per row COLS+1=252 results; frame = 252*cfg_rows results; reads = 256 + 252*(cfg_rows-1).
//  Reset mid-frame: immediate abort, all outputs to reset values, no done.
// CONFIGURATION
//  CTRL_PERF_EN defined: extra output stall_cnt[15:0].
//  CTRL_PERF_EN defined: stall_cnt counts mem_ready=0 cycles while busy; saturates at 16'hFFFF; cleared on start and on rst.
//  CTRL_PERF_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  rst 1->0 -> all outputs at reset values; ready rises after exactly 3 cycles; start before then ignored.
//  start, cfg_rows=1, mem_ready=1 -> 256 rd_en cycles (cols 0..255), 252 out_valid, out_last on 252nd, done next cycle.
//  cfg_rows=2 -> turn issue dog_x=251 rd_mode=1 rd_row=5 rd_col=251; second row dir=1, rd_col 250..0; 504 results.
//  mem_ready low 10 cycles mid-SCAN at x=100 -> dog_x=8'hFF, rd_en=0; resumes at x=100; stall_cnt=10 when CTRL_PERF_EN.
//  start with cfg_rows=0 -> done pulse next cycle, rd_en never asserted; start while busy -> no effect.
//  rst asserted at row 1 x=50 -> immediate return to reset values, no done; new start runs a full clean frame.

Source files
------------

// File: rtl/dog_scan_if.sv
// Handshake/bus bundle between the DoG frame sequencer and its environment.
// Optional macro: CTRL_PERF_EN adds the stall_cnt performance counter.
interface dog_scan_if;
  logic       start;
  logic [7:0] cfg_rows;
  logic       mem_ready;
  logic       ready;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic       rd_mode;
  logic [7:0] rd_row;
  logic [7:0] rd_col;
  logic [7:0] dog_x;
  logic [7:0] dog_y;
  logic       dog_dir;
  logic       out_valid;
  logic       out_last;
`ifdef CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  // Environment side: requests frames, supplies memory readiness.
  modport master (
    output start, cfg_rows, mem_ready,
`ifdef CTRL_PERF_EN
    input  stall_cnt,
`endif
    input  ready, busy, done, rd_en, rd_mode, rd_row, rd_col,
    input  dog_x, dog_y, dog_dir, out_valid, out_last
  );

  // Sequencer side.
  modport slave (
    input  start, cfg_rows, mem_ready,
`ifdef CTRL_PERF_EN
    output stall_cnt,
`endif
    output ready, busy, done, rd_en, rd_mode, rd_row, rd_col,
    output dog_x, dog_y, dog_dir, out_valid, out_last
  );
endinterface

// File: rtl/dog_scan_ctrl.sv
// Serpentine frame sequencer for the 5x5 DoG filter: drives Xin/Yin/Directionin,
// issues matching 5-pixel line-store reads and tags the filter's registered output.
// Optional macro: CTRL_PERF_EN adds stall_cnt (mem_ready=0 cycles while busy).
module dog_scan_ctrl #(
  parameter int COLS      = 251,
  parameter int PIPE_LAT  = 5,
  parameter int INIT_WAIT = 3
) (
  input logic      clk,
  input logic      rst,
  dog_scan_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_TURN  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int         IW        = ($clog2(INIT_WAIT + 1) < 1) ? 1 : $clog2(INIT_WAIT + 1);
  localparam logic [IW-1:0] INIT_END = IW'(INIT_WAIT);
  localparam logic [7:0] COLS_W    = 8'(COLS);
  localparam logic [7:0] COLS_M1   = 8'(COLS - 1);
  localparam logic [7:0] NOOP_X    = 8'hFF;

  logic [2:0]          state_reg;
  logic [7:0]          x_reg;
  logic [7:0]          y_reg;
  logic                dir_reg;
  logic [2:0]          prime_reg;
  logic [7:0]          rows_reg;
  logic [IW-1:0]       init_reg;
  logic                done_reg;
  logic [PIPE_LAT-1:0] vld_pipe_reg;
  logic [PIPE_LAT-1:0] last_pipe_reg;
  logic [PIPE_LAT-1:0] vld_next;
  logic [PIPE_LAT-1:0] last_next;

  logic active, issue, idle_ready, start_go, scan_end, tag_valid, tag_last;

  // Issue/tag decode shared by the FSM, the tag pipe and the output mux.
  always_comb begin
    active     = (state_reg == S_PRIME) || (state_reg == S_SCAN) || (state_reg == S_TURN);
    issue      = active && bus.mem_ready;
    idle_ready = (state_reg == S_IDLE) && (init_reg == INIT_END);
    start_go   = idle_ready && bus.start;
    scan_end   = (state_reg == S_SCAN) && (x_reg == COLS_M1);
    // While priming the window only the fifth column produces a real result.
    tag_valid  = issue && ((state_reg != S_PRIME) || (prime_reg == 3'd4));
    tag_last   = issue && scan_end && (y_reg == rows_reg - 8'd1);
  end

  // Tag shift chain: stage 0 takes the new tag, each later stage its predecessor.
  generate
    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign vld_next[gi]  = tag_valid;
        assign last_next[gi] = tag_last;
      end else begin : g_body
        assign vld_next[gi]  = vld_pipe_reg[gi-1];
        assign last_next[gi] = last_pipe_reg[gi-1];
      end
    end
  endgenerate

  // Tag pipe advances every cycle; stalls simply insert empty slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_reg  <= '0;
      last_pipe_reg <= '0;
    end else begin
      vld_pipe_reg  <= vld_next;
      last_pipe_reg <= last_next;
    end
  end

  // Frame FSM, scan position and warm-up counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      dir_reg   <= 1'b0;
      prime_reg <= '0;
      rows_reg  <= '0;
      init_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (init_reg != INIT_END) init_reg <= init_reg + IW'(1);
      case (state_reg)
        S_IDLE: begin
          if (start_go) begin
            rows_reg  <= bus.cfg_rows;
            x_reg     <= '0;
            y_reg     <= '0;
            dir_reg   <= 1'b0;
            prime_reg <= '0;
            if (bus.cfg_rows == 8'd0) done_reg <= 1'b1;
            else                      state_reg <= S_PRIME;
          end
        end
        S_PRIME: begin
          if (issue) begin
            if (prime_reg == 3'd4) begin
              state_reg <= S_SCAN;
              x_reg     <= '0;
            end else begin
              prime_reg <= prime_reg + 3'd1;
            end
          end
        end
        S_SCAN: begin
          if (issue) begin
            if (scan_end) state_reg <= (y_reg < rows_reg - 8'd1) ? S_TURN : S_DRAIN;
            else          x_reg     <= x_reg + 8'd1;
          end
        end
        S_TURN: begin
          if (issue) begin
            y_reg     <= y_reg + 8'd1;
            dir_reg   <= ~dir_reg;
            x_reg     <= '0;
            state_reg <= S_SCAN;
          end
        end
        S_DRAIN: begin
          // The final tag reaching the output means nothing else is in flight.
          if (last_pipe_reg[PIPE_LAT-1]) begin
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Read address / filter command mux; dog_x falls back to the hold code when idle or stalled.
  always_comb begin
    bus.rd_mode = 1'b0;
    bus.rd_row  = 8'd0;
    bus.rd_col  = 8'd0;
    bus.dog_x   = NOOP_X;
    bus.dog_y   = y_reg;
    bus.dog_dir = dir_reg;
    case (state_reg)
      S_PRIME: begin
        bus.rd_col = {5'd0, prime_reg};
        if (issue) bus.dog_x = 8'd0;
      end
      S_SCAN: begin
        bus.rd_row = y_reg;
        bus.rd_col = dir_reg ? (COLS_M1 - x_reg) : (x_reg + 8'd5);
        if (issue) bus.dog_x = x_reg;
      end
      S_TURN: begin
        bus.rd_mode = 1'b1;
        bus.rd_row  = y_reg + 8'd5;
        bus.rd_col  = dir_reg ? 8'd0 : COLS_W;
        if (issue) bus.dog_x = COLS_W;
      end
      default: ;
    endcase
  end

  assign bus.rd_en     = issue;
  assign bus.ready     = idle_ready;
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.done      = done_reg;
  assign bus.out_valid = vld_pipe_reg[PIPE_LAT-1];
  assign bus.out_last  = last_pipe_reg[PIPE_LAT-1];

`ifdef CTRL_PERF_EN
  logic [15:0] stall_cnt_reg;

  // Saturating count of back-pressure cycles within the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                         stall_cnt_reg <= '0;
    else if (start_go)                                               stall_cnt_reg <= '0;
    else if (bus.busy && !bus.mem_ready && stall_cnt_reg != 16'hFFFF) stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign bus.stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_dog_scan_ctrl.sv
// Directed bench for dog_scan_ctrl: warm-up, empty frame, 1/2-row frames,
// back-pressure at x=100, busy-time start, mid-frame reset and recovery.
module tb_dog_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchecks = 0;
  int   nerr    = 0;

  dog_scan_if u_if ();

  dog_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_vals(input string pfx);
    chk({pfx, "_ready"},     32'(u_if.ready),     0);
    chk({pfx, "_busy"},      32'(u_if.busy),      0);
    chk({pfx, "_done"},      32'(u_if.done),      0);
    chk({pfx, "_rd_en"},     32'(u_if.rd_en),     0);
    chk({pfx, "_rd_mode"},   32'(u_if.rd_mode),   0);
    chk({pfx, "_out_valid"}, 32'(u_if.out_valid), 0);
    chk({pfx, "_out_last"},  32'(u_if.out_last),  0);
    chk({pfx, "_dog_x"},     32'(u_if.dog_x),     255);
    chk({pfx, "_dog_y"},     32'(u_if.dog_y),     0);
    chk({pfx, "_dog_dir"},   32'(u_if.dog_dir),   0);
    chk({pfx, "_rd_row"},    32'(u_if.rd_row),    0);
    chk({pfx, "_rd_col"},    32'(u_if.rd_col),    0);
`ifdef CTRL_PERF_EN
    chk({pfx, "_stall_cnt"}, 32'(u_if.stall_cnt), 0);
`endif
  endtask

  // Expected command for the k-th issue of a frame (no dependence on stalls).
  task automatic exp_issue(input int k, output int m, output int r, output int c,
                           output int x, output int y, output int d);
    int j, q, o;
    if (k < 5) begin
      m = 0; r = 0; c = k; x = 0; y = 0; d = 0;
    end else begin
      j = k - 5;
      if (j < 251) begin
        m = 0; r = 0; c = j + 5; x = j; y = 0; d = 0;
      end else begin
        q = (j - 251) / 252 + 1;
        o = (j - 251) % 252;
        if (o == 0) begin
          y = q - 1; d = y % 2; m = 1; r = y + 5; c = (d != 0) ? 0 : 251; x = 251;
        end else begin
          y = q; d = q % 2; m = 0; r = q; x = o - 1; c = (d != 0) ? (250 - x) : (x + 5);
        end
      end
    end
  endtask

  // One frame with optional stall before issue stall_at and optional reset at issue abort_at.
  task automatic run_frame(input int rows, input int stall_at, input int stall_len, input int abort_at);
    int  k, nval, stall_left, first_rd, first_val, last_val, last_cyc, done_cyc, bad;
    int  em, er, ec, ex, ey, ed;
    bit  aborted;
    k = 0; nval = 0; stall_left = stall_len; first_rd = -1; first_val = -1;
    last_val = -1; last_cyc = -1; done_cyc = -1; bad = 0; aborted = 1'b0;
    @(posedge clk); #2;
    u_if.start = 1'b1; u_if.cfg_rows = 8'(rows); u_if.mem_ready = 1'b1;
    @(posedge clk); #2;
    u_if.start = 1'b0; u_if.cfg_rows = 8'd0;
    for (int cyc = 1; cyc < 4000 && done_cyc < 0 && !aborted; cyc++) begin
      u_if.start = (cyc == 20);
      if (stall_at >= 0 && k == stall_at && stall_left > 0) begin
        u_if.mem_ready = 1'b0;
        stall_left--;
      end else begin
        u_if.mem_ready = 1'b1;
      end
      #1;
      if (cyc == 1) begin
        chk("busy_after_start", 32'(u_if.busy), 1);
        chk("ready_while_busy", 32'(u_if.ready), 0);
      end
      if (u_if.rd_en === 1'b1) begin
        if (first_rd < 0) first_rd = cyc;
        exp_issue(k, em, er, ec, ex, ey, ed);
        if (32'(u_if.rd_mode) != em || 32'(u_if.rd_row) != er || 32'(u_if.rd_col) != ec ||
            32'(u_if.dog_x) != ex || 32'(u_if.dog_y) != ey || 32'(u_if.dog_dir) != ed) begin
          if (bad < 3)
            $display("issue %0d: mode=%0d row=%0d col=%0d x=%0d y=%0d dir=%0d want %0d/%0d/%0d/%0d/%0d/%0d",
                     k, u_if.rd_mode, u_if.rd_row, u_if.rd_col, u_if.dog_x, u_if.dog_y, u_if.dog_dir,
                     em, er, ec, ex, ey, ed);
          bad++;
        end
        if (k == abort_at) begin
          aborted = 1'b1;
          rst = 1'b1;
          #1;
          reset_vals("abort");
        end
        k++;
      end else if (u_if.dog_x !== 8'hFF) begin
        bad++;
      end
      if (!aborted) begin
        if (u_if.mem_ready == 1'b0 && u_if.rd_en !== 1'b0) bad++;
        if (u_if.out_valid === 1'b1) begin
          nval++;
          last_val = cyc;
          if (first_val < 0) first_val = cyc;
        end
        if (u_if.out_last === 1'b1) begin
          last_cyc = cyc;
          if (u_if.out_valid !== 1'b1) bad++;
        end
        if (u_if.done === 1'b1) begin
          done_cyc = cyc;
          chk("busy_at_done", 32'(u_if.busy), 0);
        end
        if (done_cyc < 0) begin
          @(posedge clk); #2;
        end
      end
    end
    u_if.start = 1'b0; u_if.mem_ready = 1'b1;
    if (!aborted) begin
      chk("frame_done_seen", 32'(done_cyc >= 0), 1);
      chk("n_reads",         k, 256 + 252 * (rows - 1));
      chk("n_results",       nval, 252 * rows);
      chk("last_on_final",   last_cyc, last_val);
      chk("done_after_last", done_cyc, last_cyc + 1);
      chk("issue_seq_bad",   bad, 0);
      chk("first_latency",   first_val - first_rd, 9);
`ifdef CTRL_PERF_EN
      chk("stall_cnt",       32'(u_if.stall_cnt), stall_len);
`endif
      @(posedge clk); #3;
      chk("done_one_cycle",  32'(u_if.done), 0);
    end else begin
      chk("abort_seq_bad", bad, 0);
    end
  endtask

  initial begin
    int ok;
    u_if.start = 1'b0; u_if.cfg_rows = 8'd0; u_if.mem_ready = 1'b1;

    // Reset release and warm-up; start before ready must be ignored.
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; #1;
    reset_vals("rst");
    u_if.start = 1'b1; u_if.cfg_rows = 8'd1;
    @(posedge clk); #3;
    chk("ready_c1", 32'(u_if.ready), 0);
    chk("busy_c1",  32'(u_if.busy),  0);
    @(posedge clk); #2; u_if.start = 1'b0; #1;
    chk("ready_c2", 32'(u_if.ready), 0);
    chk("busy_c2",  32'(u_if.busy),  0);
    @(posedge clk); #3;
    chk("ready_c3", 32'(u_if.ready), 1);
    chk("busy_c3",  32'(u_if.busy),  0);

    // Empty frame: done next cycle, no reads.
    @(posedge clk); #2; u_if.start = 1'b1; u_if.cfg_rows = 8'd0; #1;
    @(posedge clk); #2; u_if.start = 1'b0; #1;
    chk("empty_done",  32'(u_if.done),  1);
    chk("empty_rd_en", 32'(u_if.rd_en), 0);
    chk("empty_busy",  32'(u_if.busy),  0);
    ok = 1;
    repeat (4) begin
      @(posedge clk); #3;
      if (u_if.done !== 1'b0 || u_if.rd_en !== 1'b0 || u_if.busy !== 1'b0) ok = 0;
    end
    chk("empty_quiet", ok, 1);

    // Single-row frame, then two rows with a 10-cycle stall at row 0 x=100.
    run_frame(1, -1, 0, -1);
    run_frame(2, 105, 10, -1);

    // Reset at row 1 x=50: immediate abort, no done, clean recovery.
    run_frame(2, -1, 0, 307);
    ok = 1;
    repeat (2) begin
      @(posedge clk); #3;
      if (u_if.done !== 1'b0 || u_if.busy !== 1'b0) ok = 0;
    end
    chk("abort_held_quiet", ok, 1);
    rst = 1'b0; #1;
    reset_vals("rerelease");
    repeat (2) @(posedge clk);
    #3;
    chk("reready_c2", 32'(u_if.ready), 0);
    @(posedge clk); #3;
    chk("reready_c3", 32'(u_if.ready), 1);
    chk("no_done_after_abort", 32'(u_if.done), 0);
    run_frame(1, -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
